// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_param
// Description : Runtime-programmable serial bit-pattern detector. Mealy match
//               output, per-bit valid qualifier, overlap/non-overlap modes and
//               a saturating detection counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_param #(
    parameter int                  MAX_LEN     = 8,
    parameter int                  CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  RST_PATTERN = 8'b11011,
    parameter int                  RST_LEN     = 5,
    parameter logic                RST_OVERLAP = 1'b1,
    localparam int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    output logic               pattern_det,
    output logic [CNT_W-1:0]   det_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    // Active configuration and stream state
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_enough;
    logic               w_cmp;
    logic               w_match;
    logic               w_len_ok;
    logic               w_shift;
    logic [LEN_W-1:0]   w_fill_nxt;

    // Window of the most recent bits including the one arriving now
    assign w_win      = {r_hist[MAX_LEN-2:0], in_bit};
    assign w_fill_inc = {1'b0, r_fill} + 1'b1;
    assign w_enough   = (w_fill_inc >= {1'b0, r_len});
    assign w_len_ok   = (cfg_len != '0) && (cfg_len <= C_MAX_LEN);
    assign w_shift    = in_valid & ~cfg_load;

    // Mask selecting the low r_len bits of the window for comparison
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_cmp   = ((w_win & w_mask) == (r_pat & w_mask));
    // Reset gating keeps the Mealy output quiet while the history is being cleared
    assign w_match = ~rst & w_shift & ~cfg_err & w_enough & w_cmp;
    assign pattern_det = w_match;

    // Fill count saturates at MAX_LEN; non-overlap restarts it after a match
    always_comb begin
        w_fill_nxt = r_fill;
        if (w_match && !r_ovl) begin
            w_fill_nxt = '0;
        end else if (r_fill != C_MAX_LEN) begin
            w_fill_nxt = r_fill + 1'b1;
        end
    end

    // Configuration capture and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= RST_PATTERN;
            r_len   <= LEN_W'(RST_LEN);
            r_ovl   <= RST_OVERLAP;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            if (w_len_ok) begin
                r_pat   <= cfg_pattern;
                r_len   <= cfg_len;
                r_ovl   <= cfg_overlap;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Bit history and fill count; a load restarts detection from scratch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_shift) begin
            r_hist <= w_win;
            r_fill <= w_fill_nxt;
        end
    end

    // Saturating detection counter; a match in the clear cycle still counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_count <= '0;
        end else if (cnt_clr) begin
            det_count <= w_match ? CNT_W'(1) : '0;
        end else if (w_match && !(&det_count)) begin
            det_count <= det_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_param
// Description : Directed self-checking bench for seq_det_param. A default
//               instance and a CNT_W=2 instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               cnt_clr;
    logic               pattern_det;
    logic [7:0]         det_count;
    logic               cfg_err;
    logic               pattern_det2;
    logic [1:0]         det_count2;
    logic               cfg_err2;

    int n_total;
    int n_bad;

    seq_det_param dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cnt_clr     (cnt_clr),
        .pattern_det (pattern_det),
        .det_count   (det_count),
        .cfg_err     (cfg_err)
    );

    seq_det_param #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cnt_clr     (cnt_clr),
        .pattern_det (pattern_det2),
        .det_count   (det_count2),
        .cfg_err     (cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One data cycle: drive at negedge, check Mealy output, return after the edge
    task automatic step(input logic v, input logic b, input logic clr, input logic exp_det,
                        input string tag);
        @(negedge clk);
        cfg_load = 1'b0;
        cnt_clr  = clr;
        in_valid = v;
        in_bit   = b;
        #1;
        check(tag, 32'(pattern_det), 32'(exp_det));
        @(posedge clk);
        #1;
    endtask

    // Configuration load cycle with an optional valid bit that must be dropped
    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic v, input logic b);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cnt_clr     = 1'b0;
        in_valid    = v;
        in_bit      = b;
        #1;
        check("load_det", 32'(pattern_det), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] s_stream;
    logic [7:0] s_exp;

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b1;
        in_bit      = 1'b1;
        cnt_clr     = 1'b0;
        #12;
        check("rst_det", 32'(pattern_det), 32'd0);
        check("rst_count", 32'(det_count), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        // 1: default 11011, overlap: stream 1,1,0,1,1,0,1,1 (first bit at MSB)
        s_stream = 8'b11011011;
        s_exp    = 8'b00001001;
        for (int i = 7; i >= 0; i--) step(1'b1, s_stream[i], 1'b0, s_exp[i], "t1_det");
        check("t1_count", 32'(det_count), 32'd2);

        // 2: same pattern, non-overlap: only bit 5 detects
        load(8'b00011011, 4'd5, 1'b0, 1'b0, 1'b0);
        s_exp = 8'b00001000;
        for (int i = 7; i >= 0; i--) step(1'b1, s_stream[i], 1'b0, s_exp[i], "t2_det");
        check("t2_count", 32'(det_count), 32'd3);

        // 3: load 101 with a valid 1 in the load cycle, then 1,0,1,0,1
        load(8'b00000101, 4'd3, 1'b1, 1'b1, 1'b1);
        s_stream = 8'b00010101;
        s_exp    = 8'b00000101;
        for (int i = 4; i >= 0; i--) step(1'b1, s_stream[i], 1'b0, s_exp[i], "t3_det");
        check("t3_count", 32'(det_count), 32'd5);

        // 4: illegal lengths disable detection until a legal load
        load(8'b00000101, 4'd0, 1'b1, 1'b0, 1'b0);
        check("t4_err_len0", 32'(cfg_err), 32'd1);
        for (int i = 4; i >= 0; i--) step(1'b1, s_stream[i], 1'b0, 1'b0, "t4_det_len0");
        load(8'b00000101, 4'd9, 1'b1, 1'b0, 1'b0);
        check("t4_err_len9", 32'(cfg_err), 32'd1);
        for (int i = 4; i >= 0; i--) step(1'b1, s_stream[i], 1'b0, 1'b0, "t4_det_len9");
        check("t4_count_hold", 32'(det_count), 32'd5);
        load(8'b00000101, 4'd3, 1'b1, 1'b0, 1'b0);
        check("t4_err_clear", 32'(cfg_err), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t4_resume_b1");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t4_resume_b2");
        step(1'b1, 1'b1, 1'b0, 1'b1, "t4_resume_b3");
        check("t4_count", 32'(det_count), 32'd6);

        // 5: len 1 pattern 1, non-overlap; CNT_W=2 instance saturates at 3
        load(8'b00000001, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "t5_clr_det");
        check("t5_clr_count2", 32'(det_count2), 32'd0);
        check("t5_clr_count", 32'(det_count), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, "t5_det");
            check("t5_sat_count2", 32'(det_count2), (i < 3) ? 32'(i) : 32'd3);
        end
        check("t5_count8", 32'(det_count), 32'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0, "t5_zero_det");
        check("t5_zero_count2", 32'(det_count2), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1, "t5_clrmatch_det");
        check("t5_clrmatch_count2", 32'(det_count2), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "t5_clronly_det");
        check("t5_clronly_count2", 32'(det_count2), 32'd0);

        // 6: reset mid-stream restores defaults and discards history
        step(1'b1, 1'b1, 1'b0, 1'b1, "t6_pre_b1");
        step(1'b1, 1'b1, 1'b0, 1'b1, "t6_pre_b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_pre_b3");
        step(1'b1, 1'b1, 1'b0, 1'b1, "t6_pre_b4");
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        check("t6_rst_det", 32'(pattern_det), 32'd0);
        check("t6_rst_count", 32'(det_count), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, "t6_post_b1");
        step(1'b0, 1'b0, 1'b0, 1'b0, "t6_gap_a");
        step(1'b1, 1'b1, 1'b0, 1'b0, "t6_post_b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_post_b3");
        step(1'b0, 1'b1, 1'b0, 1'b0, "t6_gap_b");
        step(1'b1, 1'b1, 1'b0, 1'b0, "t6_post_b4");
        step(1'b0, 1'b1, 1'b0, 1'b0, "t6_gap_c");
        step(1'b1, 1'b1, 1'b0, 1'b1, "t6_post_b5");
        check("t6_count", 32'(det_count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
